dual_port_mem_arb: RTL

DUAL_PORT_MEM_ARB -- requirements
Module: dual_port_mem_arb

---
 rtl/dual_port_mem_arb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dual_port_mem_arb.sv
// dual_port_mem_arb: one single-port storage array shared by a read-only
// command (fetch) port and a read/write data port. The data port wins
// arbitration, except that a command request denied STARVE_LIMIT consecutive
// cycles is granted next. A granted access is captured on the grant edge and
// performed on the following edge. Read data and valid are registered, so
// valid pulses exactly one cycle after the grant edge.
// Optional feature: define MEM_BYTE_WRITE_EN to honour d_be on writes.
// Without it, every granted write updates the full word.

module dual_port_mem_arb #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int MEM_SIZE     = 1 << ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // command (fetch) read port
  input  logic                    c_req,
  input  logic [ADDR_WIDTH-1:0]   c_addr,
  output logic                    c_gnt,
  output logic                    c_valid,
  output logic [DATA_WIDTH-1:0]   c_rdata,
  // data read/write port
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_gnt,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_rdata
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [3:0]            LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH:0]   MEM_WORDS = (ADDR_WIDTH + 1)'(MEM_SIZE);

  typedef enum logic {PORT_C, PORT_D} port_e;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic [3:0]            starve_cnt;
  logic                  starve_hit;

  // Access captured on the grant edge, performed on the next edge
  logic                  p_valid;
  port_e                 p_port;
  logic                  p_we;
  logic [BE_W-1:0]       p_be;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [DATA_WIDTH-1:0] p_wdata;

  logic [BE_W-1:0]       be_in;
  logic [IDX_W-1:0]      p_idx;
  logic                  p_in_range;
  logic [DATA_WIDTH-1:0] rd_word;

`ifdef MEM_BYTE_WRITE_EN
  assign be_in = d_be;
`else
  logic unused_be;
  assign unused_be = ^d_be;
  assign be_in     = '1;
`endif

  assign starve_hit = c_req && (starve_cnt == LIMIT);
  assign p_idx      = p_addr[IDX_W-1:0];
  assign p_in_range = {1'b0, p_addr} < MEM_WORDS;
  assign rd_word    = p_in_range ? mem[p_idx] : '0;

  // Arbitration: data port first, command port once starvation limit is hit
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (d_req && !starve_hit) d_gnt = 1'b1;
      else if (c_req)           c_gnt = 1'b1;
    end
  end

  // Starvation counter: counts consecutive command denials, saturating
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst)                  starve_cnt <= '0;
    else if (!c_req || c_gnt) starve_cnt <= '0;
    else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
  end

  // Track whether an access was granted on the last edge
  always_ff @(posedge clk) begin
    if (rst) p_valid <= 1'b0;
    else     p_valid <= c_gnt || d_gnt;
  end

  // Capture the winning request's address and write payload on the grant edge
  always_ff @(posedge clk) begin
    if (c_gnt || d_gnt) begin
      p_port  <= d_gnt ? PORT_D : PORT_C;
      p_we    <= d_gnt && d_we;
      p_be    <= be_in;
      p_addr  <= d_gnt ? d_addr : c_addr;
      p_wdata <= d_wdata;
    end
  end

  // Storage write: enabled bytes only, out-of-range addresses dropped
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; contents survive rst and map onto plain RAM.
    if (!rst && p_valid && p_we && p_in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (p_be[i]) mem[p_idx][8*i +: 8] <= p_wdata[8*i +: 8];
      end
    end
  end

  // Read data and valid pulses; rdata holds until that port's next read completes
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid <= 1'b0;
      d_valid <= 1'b0;
      c_rdata <= '0;
      d_rdata <= '0;
    end else begin
      c_valid <= p_valid && (p_port == PORT_C);
      d_valid <= p_valid && (p_port == PORT_D);
      if (p_valid && !p_we) begin
        if (p_port == PORT_C) c_rdata <= rd_word;
        else                  d_rdata <= rd_word;
      end
    end
  end

endmodule
